// File: rtl/uart_wb_bridge.sv
`timescale 1ns/1ps
// uart_wb_bridge: UART-to-Wishbone classic master bridge.
// The host sends CMD, LEN, ADDR[31:0] (MSB first), then data for writes.
// CMD 0x01 writes LEN words, CMD 0x02 reads LEN words and returns each
// word MSB byte first over uart_tx. Word address wraps at 30 bits.
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   uart_rx / uart_tx   8N1 serial in / out, idle high
//   wb_cyc, wb_stb      Wishbone cycle and strobe
//   wb_we, wb_adr       write enable, 30-bit word address
//   wb_dat_w, wb_sel    write data, byte select (always all bytes)
//   wb_dat_r            read data from the slave
//   wb_ack, wb_err      transfer acknowledge / error (both end the cycle)
module uart_wb_bridge #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD        = 115200,
  parameter int TIMEOUT     = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [29:0] wb_adr,
  output logic [31:0] wb_dat_w,
  output logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_r,
  input  logic        wb_ack,
  input  logic        wb_err
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_ADDR, S_WDATA, S_WBUS, S_RBUS, S_TXWORD} state_t;

  logic            rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_t       rx_state_r;
  logic [CW-1:0]   rx_cnt_r;
  logic [2:0]      rx_bit_r;
  logic [7:0]      rx_shift_r;
  logic            rx_valid_r, rx_ferr_r;

  logic            tx_busy_r, tx_line_r, tx_sent_r;
  logic [CW-1:0]   tx_cnt_r;
  logic [3:0]      tx_bit_r;
  logic [9:0]      tx_frame_r;
  logic            tx_done_s, tx_start_s;
  logic [7:0]      tx_data_s;

  state_t          state_r, state_s;
  logic            is_write_r;
  logic [7:0]      len_r, words_left_r;
  logic [1:0]      byte_cnt_r;
  logic [TW-1:0]   to_cnt_r;
  logic [31:0]     rdata_r;
  logic            wb_cyc_r, wb_stb_r, wb_we_r;
  logic [29:0]     wb_adr_r;
  logic [31:0]     wb_dat_w_r;
  logic            wb_cyc_s, wb_we_s;
  logic            rcv_state_s, timeout_s, bus_done_s;

  assign uart_tx  = tx_line_r;
  assign wb_cyc   = wb_cyc_r;
  assign wb_stb   = wb_stb_r;
  assign wb_we    = wb_we_r;
  assign wb_adr   = wb_adr_r;
  assign wb_dat_w = wb_dat_w_r;
  assign wb_sel   = 4'hF;

  assign rcv_state_s = state_r inside {S_LEN, S_ADDR, S_WDATA};
  assign timeout_s   = rcv_state_s && (to_cnt_r == TO_LAST) && !rx_valid_r;
  assign bus_done_s  = wb_ack | wb_err;
  assign tx_done_s   = tx_busy_r && (tx_cnt_r == DIV_LAST) && (tx_bit_r == 4'd9);

  // UART receiver: synchroniser, mid-bit sampling, valid / framing-error pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_r  <= 1'b1;
      rx_sync_r  <= 1'b1;
      rx_prev_r  <= 1'b1;
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= '0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
      rx_valid_r <= 1'b0;
      rx_ferr_r  <= 1'b0;
    end else begin
      rx_meta_r  <= uart_rx;
      rx_sync_r  <= rx_meta_r;
      rx_prev_r  <= rx_sync_r;
      rx_valid_r <= 1'b0;
      rx_ferr_r  <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          rx_cnt_r <= '0;
          if (rx_prev_r && !rx_sync_r) rx_state_r <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_r == HALF_LAST) begin
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            // A start bit that is high again at mid-bit was a glitch.
            rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_r <= rx_cnt_r + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_r == DIV_LAST) begin
            rx_cnt_r   <= '0;
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            rx_bit_r   <= rx_bit_r + 3'd1;
            if (rx_bit_r == 3'd7) rx_state_r <= RX_STOP;
          end else begin
            rx_cnt_r <= rx_cnt_r + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_r == DIV_LAST) begin
            rx_cnt_r   <= '0;
            rx_valid_r <= rx_sync_r;
            rx_ferr_r  <= !rx_sync_r;
            rx_state_r <= RX_IDLE;
          end else begin
            rx_cnt_r <= rx_cnt_r + CW'(1);
          end
        end
        default: rx_state_r <= RX_IDLE;
      endcase
    end
  end

  // UART transmitter: 10-bit frame shifted out, each bit held DIV cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_busy_r  <= 1'b0;
      tx_line_r  <= 1'b1;
      tx_cnt_r   <= '0;
      tx_bit_r   <= 4'd0;
      tx_frame_r <= 10'h3FF;
    end else if (tx_start_s) begin
      tx_frame_r <= {1'b1, tx_data_s, 1'b0};
      tx_line_r  <= 1'b0;
      tx_busy_r  <= 1'b1;
      tx_cnt_r   <= '0;
      tx_bit_r   <= 4'd0;
    end else if (tx_busy_r) begin
      if (tx_cnt_r == DIV_LAST) begin
        tx_cnt_r <= '0;
        if (tx_bit_r == 4'd9) begin
          tx_busy_r <= 1'b0;
          tx_line_r <= 1'b1;
        end else begin
          tx_bit_r   <= tx_bit_r + 4'd1;
          tx_frame_r <= {1'b1, tx_frame_r[9:1]};
          tx_line_r  <= tx_frame_r[1];
        end
      end else begin
        tx_cnt_r <= tx_cnt_r + CW'(1);
      end
    end else begin
      tx_line_r <= 1'b1;
    end
  end

  // Command FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // Command FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (rx_valid_r && (rx_shift_r == 8'h01 || rx_shift_r == 8'h02)) state_s = S_LEN;
        else state_s = S_IDLE;
      end
      S_LEN: begin
        if (rx_ferr_r || timeout_s) state_s = S_IDLE;
        else if (rx_valid_r)        state_s = S_ADDR;
        else                        state_s = S_LEN;
      end
      S_ADDR: begin
        if (rx_ferr_r || timeout_s)                 state_s = S_IDLE;
        else if (rx_valid_r && byte_cnt_r == 2'd3) begin
          if (len_r == 8'd0)   state_s = S_IDLE;
          else if (is_write_r) state_s = S_WDATA;
          else                 state_s = S_RBUS;
        end else                                     state_s = S_ADDR;
      end
      S_WDATA: begin
        if (rx_ferr_r || timeout_s)                 state_s = S_IDLE;
        else if (rx_valid_r && byte_cnt_r == 2'd3)  state_s = S_WBUS;
        else                                         state_s = S_WDATA;
      end
      S_WBUS: begin
        if (bus_done_s) state_s = (words_left_r == 8'd1) ? S_IDLE : S_WDATA;
        else            state_s = S_WBUS;
      end
      S_RBUS: begin
        if (bus_done_s) state_s = S_TXWORD;
        else            state_s = S_RBUS;
      end
      S_TXWORD: begin
        // words_left was already decremented when the read completed.
        if (tx_done_s && byte_cnt_r == 2'd3) state_s = (words_left_r == 8'd0) ? S_IDLE : S_RBUS;
        else                                 state_s = S_TXWORD;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Command FSM outputs: next bus controls and TX byte launch
  always_comb begin
    wb_cyc_s   = (state_s == S_WBUS) || (state_s == S_RBUS);
    wb_we_s    = (state_s == S_WBUS);
    tx_start_s = (state_r == S_TXWORD) && !tx_busy_r && !tx_sent_r;
    case (byte_cnt_r)
      2'd0:    tx_data_s = rdata_r[31:24];
      2'd1:    tx_data_s = rdata_r[23:16];
      2'd2:    tx_data_s = rdata_r[15:8];
      default: tx_data_s = rdata_r[7:0];
    endcase
  end

  // Command datapath: byte counters, timeout, address/data assembly, bus regs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_write_r   <= 1'b0;
      len_r        <= 8'd0;
      words_left_r <= 8'd0;
      byte_cnt_r   <= 2'd0;
      to_cnt_r     <= '0;
      rdata_r      <= 32'h0;
      tx_sent_r    <= 1'b0;
      wb_cyc_r     <= 1'b0;
      wb_stb_r     <= 1'b0;
      wb_we_r      <= 1'b0;
      wb_adr_r     <= 30'h0;
      wb_dat_w_r   <= 32'h0;
    end else begin
      wb_cyc_r <= wb_cyc_s;
      wb_stb_r <= wb_cyc_s;
      wb_we_r  <= wb_we_s;
      if (state_s != state_r) byte_cnt_r <= 2'd0;
      else if ((rx_valid_r && (state_r == S_ADDR || state_r == S_WDATA)) ||
               (state_r == S_TXWORD && tx_done_s)) byte_cnt_r <= byte_cnt_r + 2'd1;
      else byte_cnt_r <= byte_cnt_r;
      if (state_s != state_r || rx_valid_r || !rcv_state_s) to_cnt_r <= '0;
      else                                                  to_cnt_r <= to_cnt_r + TW'(1);
      if (tx_start_s)     tx_sent_r <= 1'b1;
      else if (tx_done_s) tx_sent_r <= 1'b0;
      else                tx_sent_r <= tx_sent_r;
      case (state_r)
        S_IDLE:  if (rx_valid_r) is_write_r <= (rx_shift_r == 8'h01);
        S_LEN:   if (rx_valid_r) begin
          len_r        <= rx_shift_r;
          words_left_r <= rx_shift_r;
        end
        // Only the low 30 bits of the 32-bit address survive the shift.
        S_ADDR:  if (rx_valid_r) wb_adr_r <= {wb_adr_r[21:0], rx_shift_r};
        S_WDATA: if (rx_valid_r) wb_dat_w_r <= {wb_dat_w_r[23:0], rx_shift_r};
        S_WBUS:  if (bus_done_s) begin
          wb_adr_r     <= wb_adr_r + 30'd1;
          words_left_r <= words_left_r - 8'd1;
        end
        S_RBUS:  if (bus_done_s) begin
          rdata_r      <= wb_err ? 32'h0 : wb_dat_r;
          wb_adr_r     <= wb_adr_r + 30'd1;
          words_left_r <= words_left_r - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_bridge.sv
`timescale 1ns/1ps
// tb_uart_wb_bridge: drives host commands over uart_rx, models a Wishbone
// slave, decodes uart_tx, and compares bus transactions and reply bytes
// with queues filled by a command-level reference model.
module tb_uart_wb_bridge;
  localparam int CLK_FREQ_HZ = 1600000;
  localparam int BAUD        = 100000;
  localparam int DIV         = CLK_FREQ_HZ / BAUD;
  localparam int TIMEOUT     = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        wb_cyc, wb_stb, wb_we;
  logic [29:0] wb_adr;
  logic [31:0] wb_dat_w;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_r;
  logic        wb_ack, wb_err;

  uart_wb_bridge #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD(BAUD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_dat_r(wb_dat_r),
    .wb_ack(wb_ack), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic we; logic [29:0] adr; logic [31:0] dat; } txn_t;
  txn_t       exp_bus[$], got_bus[$];
  logic [7:0] exp_tx[$], got_tx[$];

  int n_checks = 0;
  int n_errors = 0;
  bit stall = 1'b0;
  bit err_mode = 1'b0;
  bit quiet = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave read data as a fixed function of the word address.
  function automatic logic [31:0] rd_data(input logic [29:0] a);
    if (a == 30'h0400_0000) return 32'hDEAD_BEEF;
    return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Wishbone slave with random latency; logs each completed transfer.
  initial begin : slave
    int dly;
    dly = 0;
    wb_ack = 1'b0; wb_err = 1'b0; wb_dat_r = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (wb_ack || wb_err) begin
        wb_ack = 1'b0; wb_err = 1'b0;
        check_eq("cyc_drop", {63'd0, wb_cyc}, 64'd0);
      end else if (wb_cyc && !stall) begin
        if (dly > 0) dly--;
        else begin
          check_eq("sel", {60'd0, wb_sel}, 64'hF);
          check_eq("stb", {63'd0, wb_stb}, 64'd1);
          got_bus.push_back({wb_we, wb_adr, wb_we ? wb_dat_w : 32'h0});
          wb_dat_r = rd_data(wb_adr);
          if (err_mode) wb_err = 1'b1; else wb_ack = 1'b1;
          dly = $urandom_range(0, 3);
        end
      end
    end
  end

  // UART decoder on uart_tx; checks start-bit width and stop bit.
  initial begin : tx_mon
    logic [7:0] b;
    int lowrun, idx;
    bit still, stop;
    forever begin
      @(posedge clk); #1;
      if (!uart_tx) begin
        lowrun = 1; still = 1'b1; b = 8'h00; stop = 1'b0;
        for (int c = 1; c < 10 * DIV; c++) begin
          @(posedge clk); #1;
          if (still && !uart_tx) lowrun++; else still = 1'b0;
          idx = c - DIV / 2;
          if (idx > 0 && idx % DIV == 0) begin
            if (idx / DIV <= 8) b[idx / DIV - 1] = uart_tx;
            else if (idx / DIV == 9) stop = uart_tx;
          end
        end
        if (!quiet) begin
          check_eq("tx_stop", {63'd0, stop}, 64'd1);
          if (b[0]) check_eq("tx_bit_len", 64'(lowrun), 64'(DIV));
        end
        got_tx.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    logic [9:0] f;
    f = {~bad_stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = 1'b1;
    if (bad_stop) repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [7:0] len, input logic [31:0] addr);
    send_byte(cmd, 1'b0);
    send_byte(len, 1'b0);
    for (int k = 3; k >= 0; k--) send_byte(addr[8*k +: 8], 1'b0);
  endtask

  // Wait for expected traffic (bounded), then compare and clear queues.
  task automatic settle();
    int c;
    c = 0;
    while ((got_bus.size() < exp_bus.size() || got_tx.size() < exp_tx.size()) && c < 30000) begin
      @(posedge clk); c++;
    end
    repeat (12 * DIV) @(posedge clk);
    check_eq("bus_count", 64'(got_bus.size()), 64'(exp_bus.size()));
    check_eq("tx_count", 64'(got_tx.size()), 64'(exp_tx.size()));
    while (got_bus.size() > 0 && exp_bus.size() > 0)
      check_eq("bus_txn", {1'b0, got_bus.pop_front()}, {1'b0, exp_bus.pop_front()});
    while (got_tx.size() > 0 && exp_tx.size() > 0)
      check_eq("tx_byte", {56'd0, got_tx.pop_front()}, {56'd0, exp_tx.pop_front()});
    got_bus.delete(); exp_bus.delete(); got_tx.delete(); exp_tx.delete();
  endtask

  // Reference model: one whole host command and its expected effects.
  task automatic do_cmd(input logic [7:0] cmd, input logic [7:0] len, input logic [31:0] addr,
                        input logic [31:0] d0);
    logic [29:0] a;
    logic [31:0] d, r;
    send_hdr(cmd, len, addr);
    for (int i = 0; i < int'(len); i++) begin
      a = addr[29:0] + 30'(i);
      if (cmd == 8'h01) begin
        d = (i == 0) ? d0 : $urandom;
        for (int k = 3; k >= 0; k--) send_byte(d[8*k +: 8], 1'b0);
        exp_bus.push_back({1'b1, a, d});
      end else begin
        exp_bus.push_back({1'b0, a, 32'h0});
        r = err_mode ? 32'h0 : rd_data(a);
        for (int k = 3; k >= 0; k--) exp_tx.push_back(r[8*k +: 8]);
      end
    end
    settle();
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int c;
    logic [7:0] cmd;
    repeat (4) @(posedge clk); #1;
    check_eq("rst_tx", {63'd0, uart_tx}, 64'd1);
    check_eq("rst_cyc", {63'd0, wb_cyc}, 64'd0);
    check_eq("rst_stb", {63'd0, wb_stb}, 64'd0);
    check_eq("rst_we", {63'd0, wb_we}, 64'd0);
    check_eq("rst_adr", {34'd0, wb_adr}, 64'd0);
    check_eq("rst_dat_w", {32'd0, wb_dat_w}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4 * DIV) @(negedge clk);

    do_cmd(8'h01, 8'd1, 32'h0000_2400, 32'h0000_000E);
    do_cmd(8'h02, 8'd1, 32'h0400_0000, 32'h0);
    do_cmd(8'h01, 8'd2, 32'h0000_2403, $urandom);
    do_cmd(8'h02, 8'd3, 32'h0000_2403, 32'h0);

    // Bad stop bit on LEN: nothing on the bus, next command still works.
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b1);
    settle();
    do_cmd(8'h01, 8'd1, 32'h0000_0100, $urandom);

    send_byte(8'h55, 1'b0);
    do_cmd(8'h02, 8'd1, 32'h0000_0200, 32'h0);

    err_mode = 1'b1;
    do_cmd(8'h02, 8'd2, 32'h0000_0300, 32'h0);
    err_mode = 1'b0;

    do_cmd(8'h01, 8'd0, 32'h0000_0400, 32'h0);
    do_cmd(8'h02, 8'd1, 32'h0000_0401, 32'h0);

    // Partial command then silence longer than the timeout.
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    repeat (TIMEOUT + 100) @(negedge clk);
    do_cmd(8'h01, 8'd1, 32'h0000_0500, $urandom);

    do_cmd(8'h01, 8'd2, 32'hFFFF_FFFF, $urandom);

    for (int n = 0; n < 8; n++) begin
      cmd = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h02;
      do_cmd(cmd, 8'($urandom_range(0, 3)), $urandom, $urandom);
    end

    // Reset while waiting for a read acknowledge.
    stall = 1'b1;
    send_hdr(8'h02, 8'd1, 32'h0000_0600);
    c = 0;
    while (!wb_cyc && c < 4000) begin @(posedge clk); #1; c++; end
    check_eq("rst_a_cyc_seen", {63'd0, wb_cyc}, 64'd1);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_a_cyc", {63'd0, wb_cyc}, 64'd0);
    check_eq("rst_a_tx", {63'd0, uart_tx}, 64'd1);
    @(negedge clk); rst_n = 1'b1; stall = 1'b0;
    settle();

    // Reset in the middle of a start bit of a reply byte.
    quiet = 1'b1;
    send_hdr(8'h02, 8'd1, 32'h0000_1000);
    exp_bus.push_back({1'b0, 30'h1000, 32'h0});
    c = 0;
    while (uart_tx && c < 4000) begin @(posedge clk); #1; c++; end
    check_eq("rst_b_tx_started", {63'd0, uart_tx}, 64'd0);
    repeat (DIV / 4) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_b_tx", {63'd0, uart_tx}, 64'd1);
    check_eq("rst_b_cyc", {63'd0, wb_cyc}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    got_tx.delete();
    quiet = 1'b0;
    settle();
    do_cmd(8'h02, 8'd1, 32'h0000_1000, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
